axi_master_line_fetch: RTL and testbench

- AXI4 read-master that fills one cache line per request: accepts a line address from the cache/fetch unit, issues one INCR burst on AR, and collects R beats into a line buffer.
- Returns the full line plus an error flag.
- Sits directly upstream of axi_slave_read_channel; its AR/R ports connect straight to it.

---
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_line_buffer.sv | 42 ++++
 rtl/axi_master_line_fetch.sv | 172 +++++++++++++++++
 tb/tb_axi_master_line_fetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi_pkg: shared AXI4 encodings and line-fetch FSM state type       |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/axi_line_buffer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi_line_buffer: BEATS x DATA_WIDTH slots, indexed write, flat out |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module axi_line_buffer #(
    parameter int BEATS      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [BEATS*DATA_WIDTH-1:0] line
);

    for (genvar k = 0; k < BEATS; k++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_q;
        logic [DATA_WIDTH-1:0] slot_d;

        always_comb begin
            slot_d = slot_q;
            if (we && (idx == IDX_W'(k))) begin
                slot_d = wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q <= '0;
            end else begin
                slot_q <= slot_d;
            end
        end

        assign line[k*DATA_WIDTH +: DATA_WIDTH] = slot_q;
    end

endmodule
`default_nettype wire

// File: rtl/axi_master_line_fetch.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | axi_master_line_fetch: one INCR AR burst per cache-line request,   |
// | R beats collected into a line buffer. Option: AXI_RD_TIMEOUT_EN    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module axi_master_line_fetch
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BEATS          = 8,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [BEATS*DATA_WIDTH-1:0] resp_line,
    output logic                        resp_err,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [ADDR_WIDTH-1:0]       ARADDR,
    output logic [LEN_WIDTH-1:0]        ARLEN,
    output logic [2:0]                  ARSIZE,
    output logic [1:0]                  ARBURST,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [DATA_WIDTH-1:0]       RDATA,
    input  logic                        RLAST,
    input  logic [1:0]                  RRESP
);

    localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_line_mask = ~(ADDR_WIDTH'(BEATS*4 - 1));

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [c_cnt_w-1:0]      beat_cnt_q, beat_cnt_d;
    logic                    err_q, err_d;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_cnt_last;
    logic w_timeout;

    assign w_ar_hs    = (state_q == ADDR) && ARREADY;
    assign w_r_hs     = (state_q == DATA) && RVALID;
    assign w_cnt_last = (beat_cnt_q == c_cnt_w'(BEATS - 1));

    assign req_ready  = (state_q == IDLE);
    assign ARVALID    = (state_q == ADDR);
    assign RREADY     = (state_q == DATA);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign ARADDR     = araddr_q;
    assign ARLEN      = LEN_WIDTH'(BEATS - 1);
    assign ARSIZE     = AXI_SIZE_4B;
    assign ARBURST    = AXI_BURST_INCR;

    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    araddr_d   = req_addr & c_line_mask;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (RVALID) begin
                    if (RRESP != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    // Early RLAST or RLAST missing on the final slot
                    if (RLAST ^ w_cnt_last) begin
                        err_d = 1'b1;
                    end
                    if (RLAST || w_cnt_last) begin
                        state_d = RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + c_cnt_w'(1);
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_timeout) begin
            err_d   = 1'b1;
            state_d = RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            araddr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef AXI_RD_TIMEOUT_EN
    localparam int c_wd_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_wd_w-1:0] wdog_q, wdog_d;
    logic              w_waiting;

    assign w_waiting = ((state_q == ADDR) || (state_q == DATA)) && !w_ar_hs && !w_r_hs;
    // Fires on the edge where the count would reach TIMEOUT_CYCLES
    assign w_timeout = w_waiting && (wdog_q == c_wd_w'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wdog_d = '0;
        if (w_waiting) begin
            wdog_d = wdog_q + c_wd_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign w_timeout          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    axi_line_buffer #(
        .BEATS      (BEATS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (c_cnt_w)
    ) u_line_buffer (
        .clk   (clk),
        .rst   (rst),
        .we    (w_r_hs),
        .idx   (beat_cnt_q),
        .wdata (RDATA),
        .line  (resp_line)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_master_line_fetch.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_axi_master_line_fetch: directed AXI slave stimulus with a       |
// | line-level reference model. Rev 1.0                                |
// +-------------------------------------------------------------------+
module tb_axi_master_line_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NB = 8;
    localparam int LW = 8;
    localparam int TO = 16;
    localparam int LINE_W = NB * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [AW-1:0]     req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_line;
    logic              resp_err;
    logic              ARVALID;
    logic              ARREADY;
    logic [AW-1:0]     ARADDR;
    logic [LW-1:0]     ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              RVALID;
    logic              RREADY;
    logic [DW-1:0]     RDATA;
    logic              RLAST;
    logic [1:0]        RRESP;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: what the line, error and AR address must be
    logic [LINE_W-1:0] m_line;
    logic              m_err;
    logic [AW-1:0]     m_addr;
    int                m_nbeats;

    logic [DW-1:0] bdata [NB];
    logic [1:0]    bresp [NB];
    logic          blast [NB];
    int            bgap  [NB];

    always #5 clk = ~clk;

    axi_master_line_fetch #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BEATS          (NB),
        .LEN_WIDTH      (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_line  (resp_line),
        .resp_err   (resp_err),
        .ARVALID    (ARVALID),
        .ARREADY    (ARREADY),
        .ARADDR     (ARADDR),
        .ARLEN      (ARLEN),
        .ARSIZE     (ARSIZE),
        .ARBURST    (ARBURST),
        .RVALID     (RVALID),
        .RREADY     (RREADY),
        .RDATA      (RDATA),
        .RLAST      (RLAST),
        .RRESP      (RRESP)
    );

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_beats(input logic [DW-1:0] base, input int last_at);
        for (int k = 0; k < NB; k++) begin
            bdata[k] = base + DW'(k);
            bresp[k] = 2'b00;
            blast[k] = (k == last_at);
            bgap[k]  = 0;
        end
    endtask

    // Burst ends at the first RLAST or at the final slot; a disagreement is an error
    task automatic model_txn(input logic [AW-1:0] addr);
        m_addr   = addr & ~AW'(NB * 4 - 1);
        m_err    = 1'b0;
        m_nbeats = NB;
        for (int k = 0; k < NB; k++) begin
            m_line[k*DW +: DW] = bdata[k];
            if (bresp[k] != 2'b00) m_err = 1'b1;
            if (blast[k] || (k == NB - 1)) begin
                if (blast[k] != (k == NB - 1)) m_err = 1'b1;
                m_nbeats = k + 1;
                break;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("arlen", ARLEN, NB - 1);
            chk("arsize", ARSIZE, 3'b010);
            chk("arburst", ARBURST, 2'b01);
            chk("one_ctrl_active", 32'(ARVALID) + 32'(RREADY) + 32'(resp_valid) + 32'(req_ready), 1);
            if (ARVALID) chk("araddr_model", ARADDR, m_addr);
            if (resp_valid) begin
                chk("resp_line_model", resp_line, m_line);
                chk("resp_err_model", resp_err, m_err);
            end
        end
    end

    task automatic run_txn(input logic [AW-1:0] addr, input int ar_dly, input int rr_dly);
        model_txn(addr);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = '0;
        chk("arvalid_latency", ARVALID, 1);
        chk("araddr_aligned", ARADDR, m_addr);
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge clk);
            chk("arvalid_hold", ARVALID, 1);
        end
        ARREADY = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        chk("arvalid_drop", ARVALID, 0);
        chk("rready_data", RREADY, 1);
        for (int k = 0; k < m_nbeats; k++) begin
            for (int g = 0; g < bgap[k]; g++) @(negedge clk);
            RVALID = 1'b1;
            RDATA  = bdata[k];
            RRESP  = bresp[k];
            RLAST  = blast[k];
            @(negedge clk);
            RVALID = 1'b0;
            RLAST  = 1'b0;
            RRESP  = 2'b00;
            if (k < m_nbeats - 1) chk("rready_mid_burst", RREADY, 1);
        end
        chk("resp_valid_latency", resp_valid, 1);
        chk("rready_after_last", RREADY, 0);
        chk("resp_line", resp_line, m_line);
        chk("resp_err", resp_err, m_err);
        for (int i = 0; i < rr_dly; i++) begin
            @(negedge clk);
            chk("resp_valid_hold", resp_valid, 1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_valid_drop", resp_valid, 0);
        chk("req_ready_after_resp", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        ARREADY    = 1'b0;
        RVALID     = 1'b0;
        RDATA      = '0;
        RLAST      = 1'b0;
        RRESP      = 2'b00;
        m_line     = '0;
        m_err      = 1'b0;
        m_addr     = '0;
        m_nbeats   = 0;
        repeat (3) @(negedge clk);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_resp_line", resp_line, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;

        // Nominal line fetch
        set_beats(32'hA0, 7);
        run_txn(32'h1000_0014, 0, 0);
        chk("nominal_araddr_lit", ARADDR, 32'h1000_0000);
        chk("nominal_line_lit", resp_line,
            {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("nominal_err_lit", resp_err, 0);

        // Backpressure on AR, gaps on R, delayed resp_ready
        set_beats(32'hB0, 7);
        bgap[2] = 1;
        bgap[5] = 2;
        run_txn(32'h2000_003F, 5, 3);
        chk("bp_line_lit", resp_line,
            {32'hB7, 32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0});

        // SLVERR on beat 3, then a clean request
        set_beats(32'hC0, 7);
        bresp[3] = 2'b10;
        run_txn(32'h3000_0000, 0, 0);
        chk("slverr_err_lit", resp_err, 1);
        set_beats(32'hD0, 7);
        run_txn(32'h3000_0020, 1, 1);
        chk("clean_err_lit", resp_err, 0);

        // Early RLAST on beat 4: slots 5..7 keep the previous line
        set_beats(32'hE0, 4);
        run_txn(32'h4000_0008, 0, 0);
        chk("early_line_lit", resp_line,
            {32'hD7, 32'hD6, 32'hD5, 32'hE4, 32'hE3, 32'hE2, 32'hE1, 32'hE0});
        chk("early_err_lit", resp_err, 1);

        // Missing RLAST on beat 7
        set_beats(32'hF0, -1);
        run_txn(32'h5000_0004, 0, 0);
        chk("nolast_err_lit", resp_err, 1);

        // Reset asserted while beat 3 is on the bus
        set_beats(32'h70, 7);
        model_txn(32'h6000_0000);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h6000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        ARREADY   = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            RVALID = 1'b1;
            RDATA  = bdata[k];
            RLAST  = 1'b0;
            @(negedge clk);
        end
        RDATA = bdata[3];
        rst   = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        RVALID = 1'b0;
        m_line = '0;
        m_err  = 1'b0;
        m_addr = '0;
        chk("midrst_arvalid", ARVALID, 0);
        chk("midrst_rready", RREADY, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp_line", resp_line, 0);
        set_beats(32'h90, 7);
        run_txn(32'h7000_007C, 2, 0);
        chk("post_rst_araddr_lit", ARADDR, 32'h7000_0060);
        chk("post_rst_err_lit", resp_err, 0);

`ifdef AXI_RD_TIMEOUT_EN
        // Silent slave: response forced TO cycles after the AR handshake
        m_addr = 32'h3000_0040;
        m_err  = 1'b1;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h3000_0044;
        @(negedge clk);
        req_valid = 1'b0;
        ARREADY   = 1'b1;
        @(negedge clk);
        ARREADY = 1'b0;
        chk("to_wait", resp_valid, 0);
        for (int i = 1; i < TO; i++) begin
            @(negedge clk);
            chk("to_wait", resp_valid, 0);
        end
        @(negedge clk);
        chk("to_resp_valid", resp_valid, 1);
        chk("to_resp_err", resp_err, 1);
        chk("to_rready", RREADY, 0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("to_req_ready", req_ready, 1);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
